// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the stream FIFO.
package fifo_pkg;

  localparam int DEF_FIFO_DEPTH   = 10;
  localparam int DEF_FULL_MARGIN  = 2;
  localparam int DEF_ALMOST_EMPTY = 2;

  // Bits needed to hold an occupancy of 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to index 0..depth-1 (depth >= 2 keeps this at least 1).
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer with a wrap bit that toggles each time it rolls over.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr,
  output logic          wrap
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (inc) begin
      if (ptr == LAST) begin
        ptr  <= '0;
        wrap <= ~wrap;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready synchronous FIFO of any depth >= 2 with exact count,
// programmable almost flags, synchronous flush and optional simultaneous full-I/O.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 64,
  parameter int C_FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int C_ALMOST_FULL  = C_FIFO_DEPTH - DEF_FULL_MARGIN,
  parameter int C_ALMOST_EMPTY = DEF_ALMOST_EMPTY,
  parameter bit C_USE_SIMUL_IO = 1'b0,
  localparam int CW = cnt_width(C_FIFO_DEPTH),
  localparam int AW = ptr_width(C_FIFO_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    write_valid,
  output logic                    write_ready,
  input  logic [C_DATA_WIDTH-1:0] write_data,
  output logic                    read_valid,
  input  logic                    read_ready,
  output logic [C_DATA_WIDTH-1:0] read_data,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(C_FIFO_DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(C_ALMOST_FULL);
  localparam logic [CW-1:0] AE_TH   = CW'(C_ALMOST_EMPTY);

  logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic          w_wrap, r_wrap;
  logic          write_commit, read_commit;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  // flush masks both handshakes so nothing commits in a flush cycle.
  assign read_valid = !empty && !flush;
  generate
    if (C_USE_SIMUL_IO) begin : g_simul
      assign write_ready = (!full || read_ready) && !flush;
    end else begin : g_plain
      assign write_ready = !full && !flush;
    end
  endgenerate

  assign write_commit = write_valid && write_ready;
  assign read_commit  = read_valid && read_ready;
  assign read_data    = mem[rp];

  fifo_ptr #(.DEPTH(C_FIFO_DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (write_commit),
    .ptr   (wp),
    .wrap  (w_wrap)
  );

  fifo_ptr #(.DEPTH(C_FIFO_DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (read_commit),
    .ptr   (rp),
    .wrap  (r_wrap)
  );

  always_ff @(posedge clk) begin
    if (write_commit) mem[wp] <= write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (write_commit && !read_commit) begin
      count <= count + 1'b1;
    end else if (read_commit && !write_commit) begin
      count <= count - 1'b1;
    end
  end

  // Occupancy implied by the pointers; the count register must track it exactly.
  logic [CW-1:0] ptr_occ;
  always_comb begin
    ptr_occ = '0;
    if (w_wrap == r_wrap) ptr_occ = CW'(wp) - CW'(rp);
    else                  ptr_occ = DEPTH_C - CW'(rp) + CW'(wp);
  end

  a_count_matches_ptrs : assert property (@(posedge clk) disable iff (reset) count == ptr_occ);

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench: DEPTH=10 plain FIFO (dut a) and DEPTH=5 simultaneous-I/O FIFO (dut b).
module tb_stream_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // dut a: DEPTH 10, AF 8, AE 2, no simultaneous I/O
  logic        a_flush = 0, a_wv = 0, a_wr, a_rv, a_rr = 0;
  logic [15:0] a_wd = '0, a_rd;
  logic [3:0]  a_cnt;
  logic        a_full, a_empty, a_af, a_ae;

  stream_fifo #(.C_DATA_WIDTH(16), .C_FIFO_DEPTH(10)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .write_valid(a_wv), .write_ready(a_wr), .write_data(a_wd),
    .read_valid(a_rv), .read_ready(a_rr), .read_data(a_rd),
    .count(a_cnt), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae)
  );

  // dut b: DEPTH 5, AF 3, AE 1, simultaneous I/O when full
  logic        b_flush = 0, b_wv = 0, b_wr, b_rv, b_rr = 0;
  logic [15:0] b_wd = '0, b_rd;
  logic [2:0]  b_cnt;
  logic        b_full, b_empty, b_af, b_ae;

  stream_fifo #(.C_DATA_WIDTH(16), .C_FIFO_DEPTH(5), .C_ALMOST_FULL(3),
                .C_ALMOST_EMPTY(1), .C_USE_SIMUL_IO(1'b1)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .write_valid(b_wv), .write_ready(b_wr), .write_data(b_wd),
    .read_valid(b_rv), .read_ready(b_rr), .read_data(b_rd),
    .count(b_cnt), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae)
  );

  logic [15:0] q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values, while asserted and after release
    #3;
    check("rst_cnt", a_cnt, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_ae", a_ae, 1);
    check("rst_af", a_af, 0);
    check("rst_rv", a_rv, 0);
    check("rst_wr", a_wr, 1);
    @(negedge clk); reset = 0;
    @(negedge clk);
    check("rel_cnt", a_cnt, 0);
    check("rel_empty", a_empty, 1);
    check("rel_ae", a_ae, 1);
    check("rel_wr", a_wr, 1);
    check("rel_rv", a_rv, 0);

    // fill dut a with 0..9, no reads
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("fill_cnt", a_cnt, i);
      check("fill_af", a_af, (i >= 8));
      check("fill_full", a_full, 0);
      check("fill_wr", a_wr, 1);
      a_wv = 1; a_wd = 16'(i);
      @(posedge clk);
    end
    @(negedge clk);
    a_wd = 16'hDEAD;
    #1;
    check("full_cnt", a_cnt, 10);
    check("full_flag", a_full, 1);
    check("full_wr", a_wr, 0);
    check("full_af", a_af, 1);
    @(posedge clk);
    @(negedge clk);
    a_wv = 0;
    check("full_hold_cnt", a_cnt, 10);

    // drain in order
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("drain_rv", a_rv, 1);
      check("drain_data", a_rd, i);
      check("drain_ae", a_ae, (10 - i <= 2));
      a_rr = 1;
      @(posedge clk);
    end
    @(negedge clk);
    a_rr = 0;
    check("drained_cnt", a_cnt, 0);
    check("drained_empty", a_empty, 1);
    check("drained_rv", a_rv, 0);

    // empty with write and read_ready together: no fall-through, only the write commits
    a_wv = 1; a_rr = 1; a_wd = 16'h00AB;
    #1;
    check("nofall_rv", a_rv, 0);
    @(posedge clk);
    @(negedge clk);
    a_wv = 0; a_rr = 0;
    check("lat_cnt", a_cnt, 1);
    check("lat_rv", a_rv, 1);
    check("lat_data", a_rd, 16'h00AB);
    a_rr = 1;
    @(posedge clk);
    @(negedge clk);
    a_rr = 0;
    check("lat_empty", a_empty, 1);

    // flush at count 6 with both handshakes requested
    for (int i = 0; i < 6; i++) begin
      a_wv = 1; a_wd = 16'h0100 + 16'(i);
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_flush_cnt", a_cnt, 6);
    a_wv = 1; a_rr = 1; a_flush = 1; a_wd = 16'h0777;
    #1;
    check("flush_wr", a_wr, 0);
    check("flush_rv", a_rv, 0);
    @(posedge clk);
    @(negedge clk);
    a_flush = 0; a_wv = 0; a_rr = 0;
    check("flush_cnt", a_cnt, 0);
    check("flush_empty", a_empty, 1);
    // flushed FIFO restarts cleanly
    a_wv = 1; a_wd = 16'h0321;
    @(posedge clk);
    @(negedge clk);
    a_wv = 0;
    check("post_flush_data", a_rd, 16'h0321);
    check("post_flush_cnt", a_cnt, 1);
    a_rr = 1;
    @(posedge clk);
    @(negedge clk);
    a_rr = 0;

    // dut b: three fill/drain rounds across pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        b_wv = 1; b_wd = 16'(r * 16 + i);
        q.push_back(b_wd);
        @(posedge clk);
        @(negedge clk);
      end
      b_wv = 0;
      check("wrap_full", b_full, 1);
      check("wrap_cnt", b_cnt, 5);
      check("wrap_wr_norr", b_wr, 0);
      for (int i = 0; i < 5; i++) begin
        check("wrap_data", b_rd, q.pop_front());
        check("wrap_rcnt", b_cnt, 5 - i);
        b_rr = 1;
        @(posedge clk);
        @(negedge clk);
      end
      b_rr = 0;
      check("wrap_empty", b_empty, 1);
    end

    // dut b: full with simultaneous write and read for 4 cycles
    for (int i = 0; i < 5; i++) begin
      b_wv = 1; b_wd = 16'h0100 + 16'(i);
      q.push_back(b_wd);
      @(posedge clk);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      b_wv = 1; b_rr = 1; b_wd = 16'h0200 + 16'(k);
      #1;
      check("simul_wr", b_wr, 1);
      check("simul_full", b_full, 1);
      check("simul_cnt", b_cnt, 5);
      check("simul_data", b_rd, q.pop_front());
      q.push_back(b_wd);
      @(posedge clk);
      @(negedge clk);
    end
    b_wv = 0; b_rr = 0;
    check("simul_end_cnt", b_cnt, 5);
    for (int i = 0; i < 5; i++) begin
      check("simul_drain", b_rd, q.pop_front());
      b_rr = 1;
      @(posedge clk);
      @(negedge clk);
    end
    b_rr = 0;
    check("simul_empty", b_empty, 1);

    // async reset between edges during a write burst on dut a
    a_wv = 1;
    for (int i = 0; i < 3; i++) begin
      a_wd = 16'h0900 + 16'(i);
      @(posedge clk);
    end
    #2;
    check("burst_cnt", a_cnt, 3);
    reset = 1;
    #1;
    check("arst_cnt", a_cnt, 0);
    check("arst_empty", a_empty, 1);
    check("arst_rv", a_rv, 0);
    check("arst_wr", a_wr, 1);
    check("arst_ae", a_ae, 1);
    a_wv = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    a_wv = 1; a_wd = 16'h05A5;
    @(posedge clk);
    @(negedge clk);
    a_wv = 0;
    check("arst_after_cnt", a_cnt, 1);
    check("arst_after_data", a_rd, 16'h05A5);
    check("arst_after_rv", a_rv, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
